// File: rtl/mii_gen_check_if.sv
// MII word stream plus checker status flags, shared between the self-test block and its observer.
// master drives the stream and flags; slave only observes them.
interface mii_gen_check_if;
  logic [63:0] o_tx_data;
  logic [7:0]  o_tx_ctrl;
  logic        payload_error;
  logic        intergap_error;
  logic        other_error;

  modport master (
    output o_tx_data,
    output o_tx_ctrl,
    output payload_error,
    output intergap_error,
    output other_error
  );

  modport slave (
    input o_tx_data,
    input o_tx_ctrl,
    input payload_error,
    input intergap_error,
    input other_error
  );
endinterface

// File: rtl/mii_gen_check.sv
// MII frame generator with an in-line checker that watches the generated stream
// and raises sticky payload, inter-frame-gap and framing error flags.
module mii_gen_check #(
  parameter int DATA_WIDTH    = 64,
  parameter int CTRL_WIDTH    = 8,
  parameter int PAYLOAD_WORDS = 8,
  parameter int IFG_WORDS     = 1,
  parameter int MIN_IFG_WORDS = 1,
  parameter int ERR_MODE      = 0
) (
  input  logic             clk,
  input  logic             i_rst,
  mii_gen_check_if.master  mii
);

  localparam logic [DATA_WIDTH-1:0] IDLE_DATA  = 64'h0707070707070707;
  localparam logic [DATA_WIDTH-1:0] START_DATA = 64'hD5555555555555FB;
  localparam logic [DATA_WIDTH-1:0] TERM_DATA  = 64'h07070707070707FD;
  localparam logic [CTRL_WIDTH-1:0] IDLE_CTRL  = 8'hFF;
  localparam logic [CTRL_WIDTH-1:0] START_CTRL = 8'h01;
  localparam logic [CTRL_WIDTH-1:0] TERM_CTRL  = 8'hFF;
  localparam logic [15:0]           LAST_WORD  = 16'(PAYLOAD_WORDS - 1);
  localparam logic [15:0]           MIN_GAP    = 16'(MIN_IFG_WORDS);

  typedef enum logic [1:0] {G_IFG, G_START, G_PAYLOAD, G_TERM} gen_state_e;
  typedef enum logic [2:0] {C_WAIT, C_PAYLOAD, C_TERM, C_GAP, C_RESYNC} chk_state_e;

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [7:0] seed, input logic [15:0] idx);
    logic [DATA_WIDTH-1:0] w;
    logic [7:0]            base;
    base = seed + 8'(idx << 3);
    for (int j = 0; j < 8; j++) w[8*j +: 8] = base + 8'(j);
    return w;
  endfunction

  gen_state_e            gen_state_q, gen_state_d;
  logic [15:0]           gcnt_q, gcnt_d;
  logic [7:0]            seed_q, seed_d;
  logic                  wrapped_q, wrapped_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [CTRL_WIDTH-1:0] tx_ctrl_q, tx_ctrl_d;

  chk_state_e            chk_state_q, chk_state_d;
  logic [15:0]           ccnt_q, ccnt_d;
  logic [15:0]           gap_q, gap_d;
  logic [7:0]            cseed_q, cseed_d;
  logic                  perr_q, perr_d, gerr_q, gerr_d, oerr_q, oerr_d;

  // Generator: the word chosen here is registered and appears on the stream next cycle.
  always_comb begin
    gen_state_d = gen_state_q;
    gcnt_d      = gcnt_q;
    seed_d      = seed_q;
    wrapped_d   = wrapped_q;
    tx_data_d   = IDLE_DATA;
    tx_ctrl_d   = IDLE_CTRL;
    case (gen_state_q)
      G_IFG: begin
        gcnt_d = gcnt_q + 16'd1;
        if (gcnt_q + 16'd1 >= 16'(IFG_WORDS)) begin
          gen_state_d = G_START;
          gcnt_d      = '0;
        end
      end
      G_START: begin
        tx_data_d   = START_DATA;
        tx_ctrl_d   = START_CTRL;
        gen_state_d = G_PAYLOAD;
        gcnt_d      = '0;
      end
      G_PAYLOAD: begin
        tx_data_d = pattern(seed_q, gcnt_q);
        tx_ctrl_d = '0;
        // Fault injection targets only the first pass through frame 2, not its wrapped aliases.
        if (ERR_MODE == 1 && seed_q == 8'd2 && !wrapped_q && gcnt_q == 16'd0)
          tx_data_d[31:24] = tx_data_d[31:24] ^ 8'hFF;
        if (ERR_MODE == 3 && seed_q == 8'd2 && !wrapped_q && gcnt_q == 16'd1)
          tx_ctrl_d[5] = 1'b1;
        if (gcnt_q == LAST_WORD) gen_state_d = G_TERM;
        else                     gcnt_d      = gcnt_q + 16'd1;
      end
      G_TERM: begin
        tx_data_d = TERM_DATA;
        tx_ctrl_d = TERM_CTRL;
        seed_d    = seed_q + 8'd1;
        if (seed_q == 8'hFF) wrapped_d = 1'b1;
        gcnt_d    = '0;
        if (IFG_WORDS == 0 || (ERR_MODE == 2 && seed_q == 8'd1 && !wrapped_q))
          gen_state_d = G_START;
        else
          gen_state_d = G_IFG;
      end
      default: gen_state_d = G_IFG;
    endcase
  end

  logic is_idle, is_start, is_term, looks_start, resync;
  logic set_p, set_g, set_o;

  // Checker: observes the registered stream, so flags trail the offending word by one cycle.
  always_comb begin
    is_idle     = (tx_data_q == IDLE_DATA)  && (tx_ctrl_q == IDLE_CTRL);
    is_start    = (tx_data_q == START_DATA) && (tx_ctrl_q == START_CTRL);
    is_term     = (tx_data_q == TERM_DATA)  && (tx_ctrl_q == TERM_CTRL);
    looks_start = tx_ctrl_q[0] && (tx_data_q[7:0] == 8'hFB);
    chk_state_d = chk_state_q;
    ccnt_d      = ccnt_q;
    gap_d       = gap_q;
    cseed_d     = cseed_q;
    resync      = 1'b0;
    set_p       = 1'b0;
    set_g       = 1'b0;
    set_o       = 1'b0;
    case (chk_state_q)
      C_WAIT: begin
        if (is_start) begin
          chk_state_d = C_PAYLOAD;
          ccnt_d      = '0;
        end else if (looks_start) begin
          set_o = 1'b1;
        end
      end
      C_PAYLOAD: begin
        set_o = (tx_ctrl_q != '0);
        set_p = (tx_data_q != pattern(cseed_q, ccnt_q));
        if (set_o || set_p)        resync      = 1'b1;
        else if (ccnt_q == LAST_WORD) chk_state_d = C_TERM;
        else                       ccnt_d      = ccnt_q + 16'd1;
      end
      C_TERM: begin
        if (is_term) begin
          chk_state_d = C_GAP;
          gap_d       = '0;
          cseed_d     = cseed_q + 8'd1;
        end else begin
          set_o  = 1'b1;
          resync = 1'b1;
        end
      end
      C_GAP: begin
        if (is_idle) begin
          if (gap_q < MIN_GAP) gap_d = gap_q + 16'd1;
        end else if (is_start) begin
          set_g       = (gap_q < MIN_GAP);
          chk_state_d = C_PAYLOAD;
          ccnt_d      = '0;
        end else begin
          set_o  = 1'b1;
          resync = 1'b1;
        end
      end
      C_RESYNC: resync = 1'b1;
      default:  chk_state_d = C_WAIT;
    endcase
    // The offending word itself may already be a valid anchor to lock back onto.
    if (resync) begin
      if (is_start) begin
        chk_state_d = C_PAYLOAD;
        ccnt_d      = '0;
      end else if (is_idle) begin
        chk_state_d = C_GAP;
        gap_d       = 16'd1;
      end else if (is_term) begin
        chk_state_d = C_GAP;
        gap_d       = '0;
        cseed_d     = cseed_q + 8'd1;
      end else begin
        chk_state_d = C_RESYNC;
      end
    end
    perr_d = perr_q | set_p;
    gerr_d = gerr_q | set_g;
    oerr_d = oerr_q | set_o;
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      gen_state_q <= G_IFG;
      gcnt_q      <= '0;
      seed_q      <= '0;
      wrapped_q   <= 1'b0;
      tx_data_q   <= IDLE_DATA;
      tx_ctrl_q   <= IDLE_CTRL;
      chk_state_q <= C_WAIT;
      ccnt_q      <= '0;
      gap_q       <= '0;
      cseed_q     <= '0;
      perr_q      <= 1'b0;
      gerr_q      <= 1'b0;
      oerr_q      <= 1'b0;
    end else begin
      gen_state_q <= gen_state_d;
      gcnt_q      <= gcnt_d;
      seed_q      <= seed_d;
      wrapped_q   <= wrapped_d;
      tx_data_q   <= tx_data_d;
      tx_ctrl_q   <= tx_ctrl_d;
      chk_state_q <= chk_state_d;
      ccnt_q      <= ccnt_d;
      gap_q       <= gap_d;
      cseed_q     <= cseed_d;
      perr_q      <= perr_d;
      gerr_q      <= gerr_d;
      oerr_q      <= oerr_d;
    end
  end

  assign mii.o_tx_data      = tx_data_q;
  assign mii.o_tx_ctrl      = tx_ctrl_q;
  assign mii.payload_error  = perr_q;
  assign mii.intergap_error = gerr_q;
  assign mii.other_error    = oerr_q;

endmodule

// File: tb/tb_mii_gen_check.sv
// Directed bench for mii_gen_check: four instances, one per fault-injection mode, share clock and reset.
module tb_mii_gen_check;

  localparam logic [63:0] IDLE_W  = 64'h0707070707070707;
  localparam logic [63:0] START_W = 64'hD5555555555555FB;
  localparam logic [63:0] TERM_W  = 64'h07070707070707FD;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   passed;

  mii_gen_check_if if0 ();
  mii_gen_check_if if1 ();
  mii_gen_check_if if2 ();
  mii_gen_check_if if3 ();

  mii_gen_check #(.ERR_MODE(0)) dut0 (.clk(clk), .i_rst(rst), .mii(if0));
  mii_gen_check #(.ERR_MODE(1)) dut1 (.clk(clk), .i_rst(rst), .mii(if1));
  mii_gen_check #(.ERR_MODE(2)) dut2 (.clk(clk), .i_rst(rst), .mii(if2));
  mii_gen_check #(.ERR_MODE(3)) dut3 (.clk(clk), .i_rst(rst), .mii(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    cyc = -1;
  endtask

  task automatic test_reset();
    logic [11:0] flags;
    rst = 1'b1;
    step();
    step();
    flags = {if0.payload_error, if0.intergap_error, if0.other_error,
             if1.payload_error, if1.intergap_error, if1.other_error,
             if2.payload_error, if2.intergap_error, if2.other_error,
             if3.payload_error, if3.intergap_error, if3.other_error};
    checks++;
    if (if0.o_tx_data !== IDLE_W) $display("FAIL reset_data got=%h exp=%h", if0.o_tx_data, IDLE_W);
    else passed++;
    checks++;
    if (if0.o_tx_ctrl !== 8'hFF) $display("FAIL reset_ctrl got=%h exp=ff", if0.o_tx_ctrl);
    else passed++;
    checks++;
    if (flags !== 12'h000) $display("FAIL reset_flags got=%h exp=000", flags);
    else passed++;
    rst = 1'b0;
    cyc = -1;
  endtask

  task automatic test_frame_format();
    run_to(0);
    checks++;
    if (if0.o_tx_data !== IDLE_W || if0.o_tx_ctrl !== 8'hFF)
      $display("FAIL first_idle got=%h/%h exp=%h/ff", if0.o_tx_data, if0.o_tx_ctrl, IDLE_W);
    else passed++;
    run_to(1);
    checks++;
    if (if0.o_tx_data !== START_W || if0.o_tx_ctrl !== 8'h01)
      $display("FAIL start_word got=%h/%h exp=%h/01", if0.o_tx_data, if0.o_tx_ctrl, START_W);
    else passed++;
    run_to(2);
    checks++;
    if (if0.o_tx_data !== 64'h0706050403020100 || if0.o_tx_ctrl !== 8'h00)
      $display("FAIL f0_word0 got=%h/%h exp=0706050403020100/00", if0.o_tx_data, if0.o_tx_ctrl);
    else passed++;
    run_to(9);
    checks++;
    if (if0.o_tx_data !== 64'h3F3E3D3C3B3A3938)
      $display("FAIL f0_word7 got=%h exp=3f3e3d3c3b3a3938", if0.o_tx_data);
    else passed++;
    run_to(10);
    checks++;
    if (if0.o_tx_data !== TERM_W || if0.o_tx_ctrl !== 8'hFF)
      $display("FAIL term_word got=%h/%h exp=%h/ff", if0.o_tx_data, if0.o_tx_ctrl, TERM_W);
    else passed++;
    run_to(11);
    checks++;
    if (if0.o_tx_data !== IDLE_W) $display("FAIL ifg_idle got=%h exp=%h", if0.o_tx_data, IDLE_W);
    else passed++;
    run_to(13);
    checks++;
    if (if0.o_tx_data !== 64'h0807060504030201)
      $display("FAIL f1_word0 got=%h exp=0807060504030201", if0.o_tx_data);
    else passed++;
  endtask

  task automatic test_error_modes();
    run_to(22);
    checks++;
    if (if2.o_tx_data !== START_W) $display("FAIL m2_early_start got=%h exp=%h", if2.o_tx_data, START_W);
    else passed++;
    checks++;
    if (if2.intergap_error !== 1'b0) $display("FAIL m2_gap_pre got=%b exp=0", if2.intergap_error);
    else passed++;
    run_to(23);
    checks++;
    if (if2.intergap_error !== 1'b1) $display("FAIL m2_gap_flag got=%b exp=1", if2.intergap_error);
    else passed++;
    run_to(24);
    checks++;
    if (if1.o_tx_data !== 64'h09080706FA040302)
      $display("FAIL m1_corrupt_word got=%h exp=09080706fa040302", if1.o_tx_data);
    else passed++;
    checks++;
    if (if1.payload_error !== 1'b0) $display("FAIL m1_payload_pre got=%b exp=0", if1.payload_error);
    else passed++;
    run_to(25);
    checks++;
    if (if1.payload_error !== 1'b1) $display("FAIL m1_payload_flag got=%b exp=1", if1.payload_error);
    else passed++;
    checks++;
    if (if3.o_tx_ctrl !== 8'h20 || if3.other_error !== 1'b0)
      $display("FAIL m3_ctrl_pre got=%h/%b exp=20/0", if3.o_tx_ctrl, if3.other_error);
    else passed++;
    run_to(26);
    checks++;
    if (if3.other_error !== 1'b1) $display("FAIL m3_other_flag got=%b exp=1", if3.other_error);
    else passed++;
    run_to(60);
    checks++;
    if ({if0.payload_error, if0.intergap_error, if0.other_error} !== 3'b000)
      $display("FAIL m0_flags got=%b%b%b exp=000", if0.payload_error, if0.intergap_error, if0.other_error);
    else passed++;
    checks++;
    if ({if1.intergap_error, if1.other_error} !== 2'b00)
      $display("FAIL m1_other_flags got=%b%b exp=00", if1.intergap_error, if1.other_error);
    else passed++;
    checks++;
    if ({if2.payload_error, if2.other_error} !== 2'b00)
      $display("FAIL m2_other_flags got=%b%b exp=00", if2.payload_error, if2.other_error);
    else passed++;
    checks++;
    if ({if3.payload_error, if3.intergap_error} !== 2'b00)
      $display("FAIL m3_other_flags got=%b%b exp=00", if3.payload_error, if3.intergap_error);
    else passed++;
  endtask

  task automatic test_seed_wrap();
    do_reset();
    run_to(2807);
    checks++;
    if (if0.o_tx_data !== 64'h06050403020100FF)
      $display("FAIL f255_word0 got=%h exp=06050403020100ff", if0.o_tx_data);
    else passed++;
    run_to(2818);
    checks++;
    if (if0.o_tx_data !== 64'h0706050403020100)
      $display("FAIL f256_word0 got=%h exp=0706050403020100", if0.o_tx_data);
    else passed++;
    run_to(2830);
    checks++;
    if ({if0.payload_error, if0.intergap_error, if0.other_error} !== 3'b000)
      $display("FAIL wrap_flags got=%b%b%b exp=000", if0.payload_error, if0.intergap_error, if0.other_error);
    else passed++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    run_to(37);
    checks++;
    if (if0.o_tx_data !== 64'h1A19181716151413)
      $display("FAIL f3_word2 got=%h exp=1a19181716151413", if0.o_tx_data);
    else passed++;
    checks++;
    if (if1.payload_error !== 1'b1) $display("FAIL m1_sticky got=%b exp=1", if1.payload_error);
    else passed++;
    rst = 1'b1;
    step();
    checks++;
    if (if0.o_tx_data !== IDLE_W || if0.o_tx_ctrl !== 8'hFF)
      $display("FAIL midrst_idle got=%h/%h exp=%h/ff", if0.o_tx_data, if0.o_tx_ctrl, IDLE_W);
    else passed++;
    checks++;
    if ({if1.payload_error, if2.intergap_error, if3.other_error} !== 3'b000)
      $display("FAIL midrst_flags got=%b%b%b exp=000", if1.payload_error, if2.intergap_error, if3.other_error);
    else passed++;
    rst = 1'b0;
    cyc = -1;
    run_to(1);
    checks++;
    if (if0.o_tx_data !== START_W) $display("FAIL restart_start got=%h exp=%h", if0.o_tx_data, START_W);
    else passed++;
    run_to(2);
    checks++;
    if (if0.o_tx_data !== 64'h0706050403020100)
      $display("FAIL restart_word0 got=%h exp=0706050403020100", if0.o_tx_data);
    else passed++;
    run_to(40);
    checks++;
    if ({if0.payload_error, if0.intergap_error, if0.other_error} !== 3'b000)
      $display("FAIL restart_flags got=%b%b%b exp=000", if0.payload_error, if0.intergap_error, if0.other_error);
    else passed++;
  endtask

  initial begin
    rst    = 1'b1;
    cyc    = -1;
    checks = 0;
    passed = 0;
    test_reset();
    test_frame_format();
    test_error_modes();
    test_seed_wrap();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
